// File: rtl/gf2m_multi_square_if.sv
// Handshake bundle for the GF(2^M) repeated-squaring unit.
//   start : request strobe from the requester (sampled only while busy=0)
//   a     : operand, polynomial basis, bit i = coefficient of x^i
//   k     : number of squarings to apply
//   d     : result a^(2^k), valid with done and held until the next accepted start
//   busy  : high from accepted start until completion
//   done  : one-cycle completion pulse
// master = requester side, slave = squaring unit side.
interface gf2m_multi_square_if #(
  parameter int unsigned M  = 233,
  parameter int unsigned KW = 8
);
  logic          start;
  logic [M-1:0]  a;
  logic [KW-1:0] k;
  logic [M-1:0]  d;
  logic          busy;
  logic          done;

  modport master (
    output start, a, k,
    input  d, busy, done
  );

  modport slave (
    input  start, a, k,
    output d, busy, done
  );
endinterface

// File: rtl/gf2m_multi_square.sv
// Sequential repeated squaring over GF(2^M) with trinomial x^M + x^T + 1.
// Computes d = a^(2^k), applying up to S squarings per clock through S chained
// combinational squarer stages. Used as the exponentiation step of Itoh-Tsujii
// inversion.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; discards any in-flight operation
//   bus   : slave side of gf2m_multi_square_if (start/a/k in, d/busy/done out)
// All outputs are registered; no combinational input-to-output path.
module gf2m_multi_square #(
  parameter int unsigned M  = 233,
  parameter int unsigned T  = 74,
  parameter int unsigned S  = 1,
  parameter int unsigned KW = 8
) (
  input logic               clk,
  input logic               rst_n,
  gf2m_multi_square_if.slave bus
);

  // Width of the spread (unreduced) square.
  localparam int unsigned W  = 2 * M - 1;
  // Width needed to hold a step count in 0..S.
  localparam int unsigned RW = (S < 2) ? 1 : $clog2(S + 1);

  typedef enum logic {StIdle, StRun} state_e;

  // One field squaring: spread bits to even positions, then fold everything at
  // or above x^M back down using x^M = x^T + 1. Walking from the top bit down
  // means a fold that lands at or above M (j-M+T >= M) is revisited later in
  // the same loop, so one descending pass covers the second reduction round.
  function automatic logic [M-1:0] sq(input logic [M-1:0] x);
    logic [W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < M; i++) begin
      t[2*i] = x[i];
    end
    for (int unsigned j = W - 1; j >= M; j--) begin
      t[j-M]   = t[j-M] ^ t[j];
      t[j-M+T] = t[j-M+T] ^ t[j];
    end
    return t[M-1:0];
  endfunction

  state_e        state_q, state_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  d_q, d_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // taps[r] = acc after r squarings, r = 0..S.
  logic [M-1:0]  taps [S+1];
  logic [RW-1:0] step_r;
  logic [M-1:0]  step_val;

  assign taps[0] = acc_q;

  for (genvar g = 1; g <= int'(S); g++) begin : g_stage
    assign taps[g] = sq(taps[g-1]);
  end

  // Final partial step applies exactly the remaining count, never S.
  always_comb begin
    if (cnt_q < KW'(S)) begin
      step_r = cnt_q[RW-1:0];
    end else begin
      step_r = RW'(S);
    end
    step_val = taps[step_r];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d = bus.a;
          cnt_d = bus.k;
          if (bus.k == '0) begin
            // Zero squarings: result is the operand itself, no RUN phase.
            d_d    = bus.a;
            done_d = 1'b1;
          end else begin
            state_d = StRun;
            busy_d  = 1'b1;
          end
        end
      end
      StRun: begin
        acc_d = step_val;
        cnt_d = cnt_q - KW'(step_r);
        if (cnt_d == '0) begin
          d_d     = step_val;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.d    = d_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_gf2m_multi_square.sv
// Directed bench for gf2m_multi_square: five instances (S = 1,2,3,4,8) share
// a, k and reset; each has its own start so runs can target any subset.
module tb_gf2m_multi_square;

  localparam int unsigned M    = 233;
  localparam int unsigned T    = 74;
  localparam int unsigned KW   = 8;
  localparam int unsigned NDUT = 5;
  localparam int unsigned SV [NDUT] = '{1, 2, 3, 4, 8};
  localparam int D1 = 0, D2 = 1, D3 = 2, D4 = 3, D8 = 4;
  localparam logic [NDUT-1:0] MaskS1 = 5'b00001;
  localparam logic [NDUT-1:0] MaskS2 = 5'b00010;
  localparam logic [NDUT-1:0] MaskS4 = 5'b01000;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDUT-1:0] start_v = '0;
  logic [M-1:0]    a_v = '0;
  logic [KW-1:0]   k_v = '0;
  logic [M-1:0]    d_v [NDUT];
  logic [NDUT-1:0] busy_v;
  logic [NDUT-1:0] done_v;

  int n_vec = 0;
  int n_bad = 0;

  // Per-run results captured by launch().
  int              lat [NDUT];
  logic [M-1:0]    res [NDUT];
  logic [NDUT-1:0] busy_seen;

  always #5 clk = ~clk;

  for (genvar g = 0; g < int'(NDUT); g++) begin : g_dut
    gf2m_multi_square_if #(.M(M), .KW(KW)) bus ();
    assign bus.start = start_v[g];
    assign bus.a     = a_v;
    assign bus.k     = k_v;
    assign d_v[g]    = bus.d;
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    gf2m_multi_square #(.M(M), .T(T), .S(SV[g]), .KW(KW)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M-1:0] rand_fe();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w[M-1:0];
  endfunction

  function automatic logic [M-1:0] mono(input int e);
    logic [M-1:0] r;
    r = '0;
    r[e] = 1'b1;
    return r;
  endfunction

  // Reference: MSB-first shift-and-add modular multiply, squaring = gmul(x, x).
  function automatic logic [M-1:0] gmul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r, red;
    logic         msb;
    red = '0;
    red[T] = 1'b1;
    red[0] = 1'b1;
    r = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      msb = r[M-1];
      r = r << 1;
      if (msb) r = r ^ red;
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] pow2k(input logic [M-1:0] x, input int kk);
    logic [M-1:0] r;
    r = x;
    for (int i = 0; i < kk; i++) r = gmul(r, r);
    return r;
  endfunction

  // Call at a negedge with the masked DUTs idle. Latency = posedges after E0
  // until done is seen (0 for k=0). Returns at the negedge where the last
  // masked DUT shows done.
  task automatic launch(input logic [NDUT-1:0] mask, input logic [M-1:0] av,
                        input logic [KW-1:0] kv);
    logic [NDUT-1:0] seen;
    seen = '0;
    busy_seen = '0;
    for (int g = 0; g < int'(NDUT); g++) begin
      lat[g] = -1;
      res[g] = '0;
    end
    a_v = av;
    k_v = kv;
    start_v = mask;
    for (int c = 0; c < 300 && ((seen & mask) != mask); c++) begin
      @(negedge clk);
      if (c == 0) begin
        start_v = '0;
        a_v = rand_fe();
        k_v = KW'($urandom);
      end
      busy_seen = busy_seen | busy_v;
      for (int g = 0; g < int'(NDUT); g++) begin
        if (mask[g] && !seen[g] && done_v[g]) begin
          seen[g] = 1'b1;
          lat[g]  = c;
          res[g]  = d_v[g];
        end
      end
    end
    chk("timeout", M'(seen & mask), M'(mask));
  endtask

  logic [M-1:0]    a1, a2, e;
  logic [NDUT-1:0] mask;
  int              idx, kk, c, hs_lat;
  logic [M-1:0]    hs_res;
  logic            any_done;

  initial begin
    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int g = 0; g < int'(NDUT); g++) begin
      chk($sformatf("rst_busy%0d", g), M'(busy_v[g]), '0);
      chk($sformatf("rst_done%0d", g), M'(done_v[g]), '0);
      chk($sformatf("rst_d%0d", g), d_v[g], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // x^117 squared = x^234 = x^1 + x^75.
    launch(MaskS1, mono(117), 8'd1);
    chk("x117_d", res[D1], mono(75) | mono(1));
    chk("x117_lat", M'(lat[D1]), M'(1));
    @(negedge clk);
    chk("done_pulse", M'(done_v[D1]), '0);

    // x^464 = x^231*(x^74+1) = x^305 + x^231; x^305 = x^146 + x^72.
    launch(MaskS1, mono(232), 8'd1);
    chk("x232_d", res[D1], mono(231) | mono(146) | mono(72));
    chk("x232_lat", M'(lat[D1]), M'(1));

    // Partial last step: S=4, k=6 -> steps of 4 then 2.
    launch(MaskS4, mono(1), 8'd6);
    chk("partial_d", res[D4], mono(64));
    chk("partial_lat", M'(lat[D4]), M'(2));

    // k=0 on every instance: immediate result, busy never raised.
    launch('1, M'(16'h1234), 8'd0);
    for (int g = 0; g < int'(NDUT); g++) begin
      chk($sformatf("k0_d%0d", g), res[g], M'(16'h1234));
      chk($sformatf("k0_lat%0d", g), M'(lat[g]), '0);
    end
    chk("k0_busy", M'(busy_seen), '0);

    // Frobenius: a^(2^233) = a.
    for (int i = 0; i < 20; i++) begin
      a1 = rand_fe();
      launch(MaskS1 | MaskS4, a1, 8'd233);
      chk($sformatf("frob_s1_d%0d", i), res[D1], a1);
      chk($sformatf("frob_s1_lat%0d", i), M'(lat[D1]), M'(233));
      chk($sformatf("frob_s4_d%0d", i), res[D4], a1);
      chk($sformatf("frob_s4_lat%0d", i), M'(lat[D4]), M'(59));
    end

    // Handshake on S=2: a start pulse while busy is ignored.
    a1 = rand_fe();
    a_v = a1;
    k_v = 8'd20;
    start_v = MaskS2;
    hs_lat = -1;
    hs_res = '0;
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) start_v = '0;
      if (c == 3) begin
        chk("hs_busy", M'(busy_v[D2]), M'(1));
        a_v = rand_fe();
        k_v = 8'd10;
        start_v = MaskS2;
      end
      if (c == 4) start_v = '0;
      if (done_v[D2]) begin
        hs_lat = c;
        hs_res = d_v[D2];
        break;
      end
    end
    chk("hs_d", hs_res, pow2k(a1, 20));
    chk("hs_lat", M'(hs_lat), M'(10));
    chk("hs_done_busy", M'(busy_v[D2]), '0);
    // Start issued in the done cycle must be accepted.
    a2 = rand_fe();
    launch(MaskS2, a2, 8'd7);
    chk("b2b_d", res[D2], pow2k(a2, 7));
    chk("b2b_lat", M'(lat[D2]), M'(4));

    // Random operands and counts against the reference model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       idx = D1;
        1:       idx = D3;
        default: idx = D8;
      endcase
      mask = '0;
      mask[idx] = 1'b1;
      a1 = rand_fe();
      kk = int'($urandom_range(0, 255));
      launch(mask, a1, KW'(kk));
      chk($sformatf("rnd_d%0d_s%0d_k%0d", i, SV[idx], kk), res[idx], pow2k(a1, kk));
      chk($sformatf("rnd_lat%0d_s%0d_k%0d", i, SV[idx], kk), M'(lat[idx]),
          M'((kk + int'(SV[idx]) - 1) / int'(SV[idx])));
    end

    // Give S=1 a nonzero d, then reset it mid-operation.
    launch(MaskS1, mono(5), 8'd3);
    chk("pre_rst_d", res[D1], mono(40));
    a_v = mono(5);
    k_v = 8'd200;
    start_v = MaskS1;
    @(negedge clk);
    start_v = '0;
    repeat (49) @(negedge clk);
    chk("mid_busy", M'(busy_v[D1]), M'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", M'(busy_v[D1]), '0);
    chk("mid_rst_done", M'(done_v[D1]), '0);
    chk("mid_rst_d", d_v[D1], '0);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (250) begin
      @(negedge clk);
      any_done = any_done | done_v[D1] | busy_v[D1];
    end
    chk("post_rst_quiet", M'(any_done), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
